// File: rtl/rn_txn_ctrl_if.sv
// rtl/rn_txn_ctrl_if.sv - command, request, data and response channels of rn_txn_ctrl
//
// Purpose: bundles every handshake channel of the transaction controller.
// Modports:
//   master - the controller side (accepts cpu commands, issues req/dtx, sinks drx, emits rsp)
//   slave  - the environment side (cpu, request target, data target)
// Signals:
//   cpu_valid/cpu_ready, cpu_write, cpu_addr, cpu_wdata   upstream command
//   req_valid/req_ready, req_opcode, req_addr             request channel (write=0, read=1)
//   dtx_valid/dtx_ready, dtx_opcode, dtx_addr, dtx_data   outbound write data
//   drx_valid/drx_ready, drx_opcode, drx_addr, drx_data   inbound read data
//   rsp_valid, rsp_err, rsp_rdata                         completion to upstream
interface rn_txn_ctrl_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int WORD_WIDTH = 8
);
  logic                  cpu_valid;
  logic                  cpu_ready;
  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [WORD_WIDTH-1:0] cpu_wdata;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_opcode;
  logic [ADDR_WIDTH-1:0] req_addr;

  logic                  dtx_valid;
  logic                  dtx_ready;
  logic                  dtx_opcode;
  logic [ADDR_WIDTH-1:0] dtx_addr;
  logic [WORD_WIDTH-1:0] dtx_data;

  logic                  drx_valid;
  logic                  drx_ready;
  logic                  drx_opcode;
  logic [ADDR_WIDTH-1:0] drx_addr;
  logic [WORD_WIDTH-1:0] drx_data;

  logic                  rsp_valid;
  logic                  rsp_err;
  logic [WORD_WIDTH-1:0] rsp_rdata;

  modport master (
    input  cpu_valid, cpu_write, cpu_addr, cpu_wdata,
    input  req_ready, dtx_ready,
    input  drx_valid, drx_opcode, drx_addr, drx_data,
    output cpu_ready,
    output req_valid, req_opcode, req_addr,
    output dtx_valid, dtx_opcode, dtx_addr, dtx_data,
    output drx_ready,
    output rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    output cpu_valid, cpu_write, cpu_addr, cpu_wdata,
    output req_ready, dtx_ready,
    output drx_valid, drx_opcode, drx_addr, drx_data,
    input  cpu_ready,
    input  req_valid, req_opcode, req_addr,
    input  dtx_valid, dtx_opcode, dtx_addr, dtx_data,
    input  drx_ready,
    input  rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/rn_txn_ctrl.sv
// rtl/rn_txn_ctrl.sv - single-outstanding read/write transaction controller
//
// Purpose: accepts one cpu command at a time, issues it on the request channel,
// moves write data out on dtx or collects read data on drx, then pulses rsp_valid.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    rn_txn_ctrl_if.master (all handshake channels)
// Optional feature: define RN_TIMEOUT_EN to bound the DATA wait to TIMEOUT_CYCLES
// cycles, after which the transaction completes with rsp_err=1.
module rn_txn_ctrl #(
  parameter int ADDR_WIDTH     = 3,
  parameter int WORD_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  rn_txn_ctrl_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("rn_txn_ctrl: TIMEOUT_CYCLES must be within 1..255");
  end

  localparam logic OP_WRITE        = 1'b0;
  localparam logic OP_READ         = 1'b1;
  localparam logic OP_DATA_RECV    = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_wdata;

  logic                  r_cpu_ready;
  logic                  r_req_valid;
  logic                  r_dtx_valid;
  logic                  r_drx_ready;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [WORD_WIDTH-1:0] r_rsp_rdata;

`ifdef RN_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]            r_to_cnt;
`endif

  // The data-phase handshake: only one of dtx/drx is armed in DATA, chosen by
  // the latched direction, so the other channel's valid/ready is ignored.
  logic w_data_hs;
  logic w_rd_good;

  assign w_data_hs = r_write ? (r_dtx_valid & bus.dtx_ready)
                             : (r_drx_ready & bus.drx_valid);
  assign w_rd_good = (bus.drx_opcode == OP_DATA_RECV) && (bus.drx_addr == r_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_ready <= 1'b1;
      r_req_valid <= 1'b0;
      r_dtx_valid <= 1'b0;
      r_drx_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef RN_TIMEOUT_EN
      r_to_cnt    <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cpu_ready <= 1'b1;
          if (bus.cpu_valid && r_cpu_ready) begin
            r_write     <= bus.cpu_write;
            r_addr      <= bus.cpu_addr;
            r_wdata     <= bus.cpu_wdata;
            r_cpu_ready <= 1'b0;
            r_req_valid <= 1'b1;
            r_state     <= S_REQ;
          end
        end

        S_REQ: begin
          if (bus.req_ready) begin
            r_req_valid <= 1'b0;
            r_dtx_valid <= r_write;
            r_drx_ready <= ~r_write;
`ifdef RN_TIMEOUT_EN
            r_to_cnt    <= 8'd0;
`endif
            r_state     <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_data_hs) begin
            r_dtx_valid <= 1'b0;
            r_drx_ready <= 1'b0;
            r_rsp_valid <= 1'b1;
            if (r_write) begin
              r_rsp_err   <= 1'b0;
              r_rsp_rdata <= '0;
            end else if (w_rd_good) begin
              r_rsp_err   <= 1'b0;
              r_rsp_rdata <= bus.drx_data;
            end else begin
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end
            r_state     <= S_RESP;
          end
`ifdef RN_TIMEOUT_EN
          // The counter holds the number of finished idle DATA cycles, so the
          // edge that would bring it to TIMEOUT_CYCLES is the expiry edge.
          else if (r_to_cnt == TO_LAST) begin
            r_dtx_valid <= 1'b0;
            r_drx_ready <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= S_RESP;
          end else begin
            r_to_cnt    <= r_to_cnt + 8'd1;
          end
`endif
        end

        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_cpu_ready <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: begin
          r_state     <= S_IDLE;
          r_cpu_ready <= 1'b1;
          r_req_valid <= 1'b0;
          r_dtx_valid <= 1'b0;
          r_drx_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_ready  = r_cpu_ready;
  assign bus.req_valid  = r_req_valid;
  assign bus.req_opcode = r_write ? OP_WRITE : OP_READ;
  assign bus.req_addr   = r_addr;
  assign bus.dtx_valid  = r_dtx_valid;
  assign bus.dtx_opcode = OP_DATA_RECV;
  assign bus.dtx_addr   = r_addr;
  assign bus.dtx_data   = r_wdata;
  assign bus.drx_ready  = r_drx_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.rsp_rdata  = r_rsp_rdata;

endmodule

// File: tb/tb_rn_txn_ctrl.sv
// tb/tb_rn_txn_ctrl.sv - directed self-checking bench for rn_txn_ctrl
module tb_rn_txn_ctrl;

  localparam int AW = 3;
  localparam int WW = 8;
  localparam int TO = 15;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rn_txn_ctrl_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  rn_txn_ctrl #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    bus.cpu_valid  = 1'b0;
    bus.cpu_write  = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.req_ready  = 1'b0;
    bus.dtx_ready  = 1'b0;
    bus.drx_valid  = 1'b0;
    bus.drx_opcode = 1'b0;
    bus.drx_addr   = '0;
    bus.drx_data   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.cpu_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cpu_ready actual=%b required=1", bus.cpu_ready);
    end
    n_checks++;
    if ({bus.req_valid, bus.dtx_valid, bus.drx_ready, bus.rsp_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_valids actual=%b required=0000",
                         {bus.req_valid, bus.dtx_valid, bus.drx_ready, bus.rsp_valid});
    end
    n_checks++;
    if ({bus.rsp_err, bus.rsp_rdata, bus.dtx_data, bus.req_addr} !== 20'h0) begin
      n_fail++; $display("FAIL reset_fields actual=%h required=0",
                         {bus.rsp_err, bus.rsp_rdata, bus.dtx_data, bus.req_addr});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.cpu_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_cpu_ready actual=%b required=1", bus.cpu_ready);
    end
  endtask

  task automatic test_read_ok();
    bus.cpu_valid = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 3'd5; bus.cpu_wdata = 8'hFF;
    bus.req_ready = 1'b1;
    bus.drx_valid = 1'b1; bus.drx_opcode = 1'b0; bus.drx_addr = 3'd5; bus.drx_data = 8'hA7;
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    n_checks++;
    if ({bus.req_valid, bus.req_opcode, bus.req_addr, bus.cpu_ready, bus.drx_ready} !== 7'b1_1_101_0_0) begin
      n_fail++; $display("FAIL read_req actual=%b required=1110100",
                         {bus.req_valid, bus.req_opcode, bus.req_addr, bus.cpu_ready, bus.drx_ready});
    end
    @(negedge clk);
    n_checks++;
    if ({bus.req_valid, bus.drx_ready, bus.dtx_valid, bus.rsp_valid} !== 4'b0100) begin
      n_fail++; $display("FAIL read_data_phase actual=%b required=0100",
                         {bus.req_valid, bus.drx_ready, bus.dtx_valid, bus.rsp_valid});
    end
    @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, 8'hA7}) begin
      n_fail++; $display("FAIL read_rsp actual=%b/%b/%h required=1/0/a7",
                         bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    bus.drx_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.cpu_ready, bus.rsp_rdata} !== {2'b01, 8'hA7}) begin
      n_fail++; $display("FAIL read_hold actual=%b/%b/%h required=0/1/a7",
                         bus.rsp_valid, bus.cpu_ready, bus.rsp_rdata);
    end
  endtask

  task automatic test_read_err();
    for (int k = 0; k < 2; k++) begin
      bus.cpu_valid = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 3'd1;
      bus.req_ready = 1'b1;
      bus.drx_valid = 1'b1; bus.drx_data = 8'h5A;
      bus.drx_opcode = (k == 0) ? 1'b1 : 1'b0;
      bus.drx_addr   = (k == 0) ? 3'd1 : 3'd6;
      @(negedge clk);
      bus.cpu_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b11, 8'h00}) begin
        n_fail++; $display("FAIL read_err_case%0d actual=%b/%b/%h required=1/1/00",
                           k, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
      end
      bus.drx_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_write_stall();
    bus.cpu_valid = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 3'd2; bus.cpu_wdata = 8'h3C;
    bus.req_ready = 1'b0; bus.dtx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.cpu_valid = 1'b0;
      n_checks++;
      if ({bus.req_valid, bus.req_opcode, bus.req_addr} !== 5'b1_0_010) begin
        n_fail++; $display("FAIL write_req_hold_cyc%0d actual=%b required=10010",
                           i, {bus.req_valid, bus.req_opcode, bus.req_addr});
      end
      if (i == 4) bus.req_ready = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.dtx_valid, bus.dtx_opcode, bus.dtx_addr, bus.dtx_data, bus.req_valid, bus.drx_ready}
          !== {5'b1_0_010, 8'h3C, 2'b00}) begin
        n_fail++; $display("FAIL write_dtx_cyc%0d actual=%b/%b/%h/%h req=%b drx_ready=%b required=1/0/2/3c req=0 drx_ready=0",
                           i, bus.dtx_valid, bus.dtx_opcode, bus.dtx_addr, bus.dtx_data,
                           bus.req_valid, bus.drx_ready);
      end
      if (i == 1) bus.dtx_ready = 1'b1;
    end
    @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.dtx_valid} !== {2'b10, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL write_rsp actual=%b/%b/%h dtx=%b required=1/0/00 dtx=0",
                         bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.dtx_valid);
    end
    bus.dtx_ready = 1'b0; bus.req_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_busy();
    int pulses;
    int reqs;
    bus.cpu_valid = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 3'd3;
    bus.req_ready = 1'b1; bus.drx_valid = 1'b0;
    @(negedge clk);
    bus.cpu_write = 1'b1; bus.cpu_addr = 3'd7;
    n_checks++;
    if (bus.cpu_ready !== 1'b0) begin
      n_fail++; $display("FAIL busy_cpu_ready_req actual=%b required=0", bus.cpu_ready);
    end
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    n_checks++;
    if ({bus.cpu_ready, bus.drx_ready, bus.dtx_valid} !== 3'b010) begin
      n_fail++; $display("FAIL busy_data_phase actual=%b required=010",
                         {bus.cpu_ready, bus.drx_ready, bus.dtx_valid});
    end
    bus.drx_valid = 1'b1; bus.drx_opcode = 1'b0; bus.drx_addr = 3'd3; bus.drx_data = 8'h96;
    pulses = 0; reqs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) pulses++;
      if (bus.req_valid === 1'b1) reqs++;
      if (i == 0) bus.drx_valid = 1'b0;
    end
    n_checks++;
    if (pulses != 1 || reqs != 0) begin
      n_fail++; $display("FAIL busy_single_rsp actual=pulses %0d reqs %0d required=pulses 1 reqs 0",
                         pulses, reqs);
    end
    n_checks++;
    if (bus.rsp_rdata !== 8'h96) begin
      n_fail++; $display("FAIL busy_rdata actual=%h required=96", bus.rsp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    bus.cpu_valid = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 3'd4; bus.cpu_wdata = 8'h11;
    bus.req_ready = 1'b1; bus.dtx_ready = 1'b0;
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.dtx_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_dtx_before actual=%b required=1", bus.dtx_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.dtx_valid, bus.rsp_valid, bus.req_valid, bus.rsp_err, bus.rsp_rdata} !== 12'h0) begin
      n_fail++; $display("FAIL rstmid_outputs actual=%b/%b/%b/%b/%h required=0/0/0/0/00",
                         bus.dtx_valid, bus.rsp_valid, bus.req_valid, bus.rsp_err, bus.rsp_rdata);
    end
    rst_n = 1'b1; bus.req_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || bus.cpu_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_release actual=pulses %0d cpu_ready %b required=pulses 0 cpu_ready 1",
                         pulses, bus.cpu_ready);
    end
  endtask

  task automatic test_timeout();
    int first;
    logic err;
    logic [WW-1:0] rdata;
    bus.cpu_valid = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 3'd0;
    bus.req_ready = 1'b1; bus.drx_valid = 1'b0;
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    first = 0; err = 1'b0; rdata = '1;
    for (int c = 2; c <= 110 && first == 0; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        first = c; err = bus.rsp_err; rdata = bus.rsp_rdata;
      end
    end
`ifdef RN_TIMEOUT_EN
    n_checks++;
    if (first != TO + 2) begin
      n_fail++; $display("FAIL timeout_latency actual=%0d required=%0d", first, TO + 2);
    end
    n_checks++;
    if ({err, rdata, bus.drx_ready} !== {1'b1, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL timeout_rsp actual=%b/%h drx_ready=%b required=1/00 drx_ready=0",
                         err, rdata, bus.drx_ready);
    end
`else
    n_checks++;
    if (first != 0 || bus.drx_ready !== 1'b1) begin
      n_fail++; $display("FAIL no_timeout actual=rsp at %0d drx_ready %b required=no rsp drx_ready 1",
                         first, bus.drx_ready);
    end
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_read_ok();
    test_read_err();
    test_write_stall();
    test_busy();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
